mem_port_arbiter: RTL and testbench

Shares the single synchronous-read memory port between the CPU core (instruction fetch, loads, stores) and a read-only device requester (display/DMA reader). Grants at most one access per cycle, steers returned read data into per-requester hold registers, and bounds device starvation. Sits between the CPU's memory interface and the memory block; the CPU treats a withheld grant as a stall.

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 52 +++++
 tb/tb_mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU, device and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_grant;
  logic [15:0] cpu_rdata;
  logic        cpu_valid;
  logic        dev_req;
  logic [15:0] dev_addr;
  logic        dev_grant;
  logic [15:0] dev_rdata;
  logic        dev_valid;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;
  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, dev_req, dev_addr, mem_rdata,
    input  cpu_grant, cpu_rdata, cpu_valid, dev_grant, dev_rdata, dev_valid,
           mem_addr, mem_wdata, mem_write
  );
  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, dev_req, dev_addr, mem_rdata,
    output cpu_grant, cpu_rdata, cpu_valid, dev_grant, dev_rdata, dev_valid,
           mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority arbiter for one sync-read memory port with per-requester read return.
// Define ARB_STARVE_GUARD_EN to force the device in after STARVE_LIMIT consecutive CPU grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_CPU, RD_DEV} state_t;
  state_t state, state_nxt;
  logic cpu_win, dev_win, force_dev;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("STARVE_LIMIT must be 1..15");
  end
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign force_dev = bus.dev_req && starve == 4'(STARVE_LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else if (!bus.dev_req || dev_win) starve <= '0;
    else if (cpu_win && starve != 4'(STARVE_LIMIT)) starve <= starve + 4'd1;
`else
  assign force_dev = 1'b0;
`endif
  // Gating with rst_n keeps grants and the memory bus quiet while reset is held.
  assign cpu_win = rst_n && bus.cpu_req && !force_dev;
  assign dev_win = rst_n && bus.dev_req && (!bus.cpu_req || force_dev);
  always_comb begin
    state_nxt     = cpu_win && !bus.cpu_write ? RD_CPU : dev_win ? RD_DEV : IDLE;
    bus.cpu_grant = cpu_win;
    bus.dev_grant = dev_win;
    bus.mem_addr  = cpu_win ? bus.cpu_addr : dev_win ? bus.dev_addr : '0;
    bus.mem_wdata = cpu_win ? bus.cpu_wdata : '0;
    bus.mem_write = cpu_win && bus.cpu_write;
  end
  // State names the read issued last cycle, so its data is on mem_rdata now.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      bus.cpu_rdata <= '0;
      bus.dev_rdata <= '0;
      bus.cpu_valid <= 1'b0;
      bus.dev_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.cpu_valid <= state == RD_CPU;
      bus.dev_valid <= state == RD_DEV;
      if (state == RD_CPU) bus.cpu_rdata <= bus.mem_rdata;
      if (state == RD_DEV) bus.dev_rdata <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a sync-read memory model behind the arbiter.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [15:0] mem [65536];
  logic [15:0] cq_d[$], dq_d[$];
  int cq_t[$], dq_t[$];
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  // Expected read data is taken from the address the bench drove, not the one the DUT issued.
  always @(negedge clk) begin
    if (!rst_n) begin
      cq_d.delete(); cq_t.delete(); dq_d.delete(); dq_t.delete();
    end else begin
      if (bus.cpu_grant && !bus.cpu_write) begin cq_d.push_back(mem[bus.cpu_addr]); cq_t.push_back(cyc + 2); end
      if (bus.dev_grant) begin dq_d.push_back(mem[bus.dev_addr]); dq_t.push_back(cyc + 2); end
      check("grant_onehot", {15'd0, bus.cpu_grant & bus.dev_grant}, 16'd0);
      if (bus.cpu_valid) begin
        if (cq_d.size() == 0) check("cpu_valid_spurious", 16'd1, 16'd0);
        else begin
          check("cpu_rdata", bus.cpu_rdata, cq_d.pop_front());
          check("cpu_latency", 16'(cyc), 16'(cq_t.pop_front()));
        end
      end
      if (cq_t.size() != 0 && cq_t[0] <= cyc) begin check("cpu_valid_missing", 16'd0, 16'd1); void'(cq_d.pop_front()); void'(cq_t.pop_front()); end
      if (bus.dev_valid) begin
        if (dq_d.size() == 0) check("dev_valid_spurious", 16'd1, 16'd0);
        else begin
          check("dev_rdata", bus.dev_rdata, dq_d.pop_front());
          check("dev_latency", 16'(cyc), 16'(dq_t.pop_front()));
        end
      end
      if (dq_t.size() != 0 && dq_t[0] <= cyc) begin check("dev_valid_missing", 16'd0, 16'd1); void'(dq_d.pop_front()); void'(dq_t.pop_front()); end
    end
  end
  task automatic step(input string tag, input logic cr, input logic cw, input logic [15:0] ca,
                      input logic [15:0] cd, input logic dr, input logic [15:0] da,
                      input logic ec, input logic ed);
    @(posedge clk);
    #1;
    bus.cpu_req = cr; bus.cpu_write = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dev_req = dr; bus.dev_addr = da;
    @(negedge clk);
    check({tag, "_cpu_grant"}, {15'd0, bus.cpu_grant}, {15'd0, ec});
    check({tag, "_dev_grant"}, {15'd0, bus.dev_grant}, {15'd0, ed});
  endtask
  initial begin
    logic [15:0] ca, da;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h7777;
    bus.dev_req = 1'b1; bus.dev_addr = 16'h0030;
    mem[16'h0010] = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rst_cpu_grant", {15'd0, bus.cpu_grant}, 16'd0);
    check("rst_dev_grant", {15'd0, bus.dev_grant}, 16'd0);
    check("rst_mem_addr", bus.mem_addr, 16'd0);
    check("rst_mem_wdata", bus.mem_wdata, 16'd0);
    check("rst_mem_write", {15'd0, bus.mem_write}, 16'd0);
    check("rst_cpu_valid", {15'd0, bus.cpu_valid}, 16'd0);
    check("rst_dev_valid", {15'd0, bus.dev_valid}, 16'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 16'd0);
    check("rst_dev_rdata", bus.dev_rdata, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_cpu_grant", {15'd0, bus.cpu_grant}, 16'd1);
    check("rel_dev_grant", {15'd0, bus.dev_grant}, 16'd0);
    check("rel_mem_addr", bus.mem_addr, 16'h0010);
    repeat (4) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("cpu_rdata_hold", bus.cpu_rdata, 16'hBEEF);
    step("wr", 1, 1, 16'h0020, 16'h1234, 0, 0, 1, 0);
    check("wr_mem_write", {15'd0, bus.mem_write}, 16'd1);
    check("wr_mem_addr", bus.mem_addr, 16'h0020);
    check("wr_mem_wdata", bus.mem_wdata, 16'h1234);
    step("wr_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("wr_done_mem_write", {15'd0, bus.mem_write}, 16'd0);
    step("wr_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("wr_no_valid", {15'd0, bus.cpu_valid}, 16'd0);
    step("rdback", 1, 0, 16'h0020, 0, 0, 0, 1, 0);
    repeat (3) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    ca = 16'h0100; da = 16'h0200;
    for (int i = 0; i < 3 * (LIM + 1); i++) begin
      logic ed;
`ifdef ARB_STARVE_GUARD_EN
      ed = (i % (LIM + 1)) == LIM;
`else
      ed = 1'b0;
`endif
      step("both", 1, 0, ca, 0, 1, da, !ed, ed);
      if (ed) da = da + 16'd1; else ca = ca + 16'd1;
    end
    repeat (3) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) step("alt_cpu", 1, 0, 16'h0040 + 16'(i), 0, 0, 0, 1, 0);
      else step("alt_dev", 0, 0, 0, 0, 1, 16'h0080 + 16'(i), 0, 1);
    repeat (3) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("dev_rdata_loaded", bus.dev_rdata, 16'h0087 ^ 16'h5A5A);
    step("rd_dev", 0, 0, 0, 0, 1, 16'h0055, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; bus.dev_req = 1'b0;
    @(negedge clk);
    check("midrst_dev_valid", {15'd0, bus.dev_valid}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_dev_valid", {15'd0, bus.dev_valid}, 16'd0);
    check("postrst_dev_rdata", bus.dev_rdata, 16'd0);
    @(negedge clk);
    check("postrst_dev_valid2", {15'd0, bus.dev_valid}, 16'd0);
    repeat (2) step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("cpu_q_drained", 16'(cq_d.size()), 16'd0);
    check("dev_q_drained", 16'(dq_d.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
